// File: rtl/mod_counter.sv
// Up/down modulo counter with load, clear, prescaler,
// wrap/saturate modes, terminal-count pulse and sticky overflow.
module mod_counter #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic             up,
  input  logic             sat,
  input  logic [WIDTH-1:0] limit,
  input  logic [PRE_W-1:0] pre,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [PRE_W-1:0] pcnt_q, pcnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;

  always_comb begin
    count_d = count_q;
    pcnt_d  = pcnt_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    step    = 1'b0;
    if (clr) begin
      count_d = '0;
      pcnt_d  = '0;
      ovf_d   = 1'b0;
    end else if (ld) begin
      count_d = (data > limit) ? limit : data;
      pcnt_d  = '0;
    end else if (en) begin
      if (pcnt_q == pre) begin
        pcnt_d = '0;
        step   = 1'b1;
      end else begin
        pcnt_d = pcnt_q + PRE_W'(1);
      end
    end
    // Bounds are compared before the add/subtract, so nothing overflows.
    if (step) begin
      if (up) begin
        if (count_q < limit) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          tc_d = 1'b1;
          if (sat) begin
            count_d = limit;
          end else begin
            count_d = '0;
            ovf_d   = 1'b1;
          end
        end
      end else begin
        if (count_q > limit) begin
          count_d = limit;
        end else if (count_q != '0) begin
          count_d = count_q - WIDTH'(1);
        end else begin
          tc_d = 1'b1;
          if (!sat) begin
            count_d = limit;
            ovf_d   = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      pcnt_q  <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      pcnt_q  <= pcnt_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: directed vector table, hand sequences
// and random stimulus against an arithmetic reference model.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       rst, clr, ld, en, up, sat;
  logic [7:0] data, limit;
  logic [3:0] pre;
  logic [7:0] count;
  logic       tc, ovf;

  int n_run  = 0;
  int n_fail = 0;

  int m_c, m_p, m_tc, m_ov;

  typedef struct {
    bit       rst, clr, ld;
    bit [7:0] data;
    bit       en, up, sat;
    bit [7:0] limit;
    bit [3:0] pre;
    int       ec, etc, eov;
  } vec_t;

  vec_t tbl[$];

  mod_counter #(.WIDTH(8), .PRE_W(4)) dut (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld),
    .data(data), .en(en), .up(up), .sat(sat),
    .limit(limit), .pre(pre),
    .count(count), .tc(tc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    bit r, bit c, bit l, int d, bit e, bit u, bit s,
    int lim, int p, int ec, int et, int eo);
    vec_t v;
    v.rst = r; v.clr = c; v.ld = l; v.data = 8'(d);
    v.en = e; v.up = u; v.sat = s;
    v.limit = 8'(lim); v.pre = 4'(p);
    v.ec = ec; v.etc = et; v.eov = eo;
    return v;
  endfunction

  task automatic chk(string nm, int got, int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)",
               nm, got, exp, $time);
    end
  endtask

  // Reference model: next state from the rules with plain integers.
  task automatic model_edge();
    int lim;
    bit stp;
    lim = int'(limit);
    stp = 0;
    m_tc = 0;
    if (rst || clr) begin
      m_c = 0; m_p = 0; m_ov = 0;
    end else if (ld) begin
      m_c = (int'(data) < lim) ? int'(data) : lim;
      m_p = 0;
    end else if (en) begin
      if (m_p == int'(pre)) begin
        m_p = 0; stp = 1;
      end else begin
        m_p = (m_p + 1) % 16;
      end
    end
    if (stp && up) begin
      if (m_c < lim) m_c = m_c + 1;
      else begin
        m_tc = 1;
        if (sat) m_c = lim;
        else begin m_c = 0; m_ov = 1; end
      end
    end else if (stp) begin
      if (m_c > lim) m_c = lim;
      else if (m_c > 0) m_c = m_c - 1;
      else begin
        m_tc = 1;
        if (!sat) begin m_c = lim; m_ov = 1; end
      end
    end
  endtask

  task automatic cyc(string nm);
    @(posedge clk);
    model_edge();
    #1;
    chk({nm, ".count"}, int'(count), m_c);
    chk({nm, ".tc"},    int'(tc),    m_tc);
    chk({nm, ".ovf"},   int'(ovf),   m_ov);
  endtask

  task automatic drive(vec_t v);
    rst = v.rst; clr = v.clr; ld = v.ld; data = v.data;
    en = v.en; up = v.up; sat = v.sat;
    limit = v.limit; pre = v.pre;
  endtask

  initial begin
    m_c = 0; m_p = 0; m_tc = 0; m_ov = 0;
    rst = 1; clr = 0; ld = 0; data = 0; en = 0;
    up = 1; sat = 0; limit = 5; pre = 0;

    // reset and hold
    for (int i = 0; i < 2; i++)
      tbl.push_back(mk(1,0,0,0,0,1,0,5,0, 0,0,0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,0,0,0,0,1,0,5,0, 0,0,0));
    // wrap up, limit 5
    tbl.push_back(mk(0,0,0,0,1,1,0,5,0, 1,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,5,0, 2,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,5,0, 3,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,5,0, 4,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,5,0, 5,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,5,0, 0,1,1));
    tbl.push_back(mk(0,0,0,0,1,1,0,5,0, 1,0,1));
    tbl.push_back(mk(0,0,0,0,1,1,0,5,0, 2,0,1));
    // clear, then saturate down with prescale 2
    tbl.push_back(mk(0,1,0,0,0,1,0,5,0, 0,0,0));
    tbl.push_back(mk(0,0,1,3,0,0,1,5,2, 3,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,1,5,2, 3,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,1,5,2, 3,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,1,5,2, 2,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,1,5,2, 2,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,1,5,2, 2,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,1,5,2, 1,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,1,5,2, 1,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,1,5,2, 1,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,1,5,2, 0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,1,5,2, 0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,1,5,2, 0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,1,5,2, 0,1,0));
    tbl.push_back(mk(0,0,0,0,1,0,1,5,2, 0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,1,5,2, 0,0,0));
    tbl.push_back(mk(0,0,0,0,1,0,1,5,2, 0,1,0));
    // load clamp and limit lowering
    tbl.push_back(mk(0,0,1,200,0,1,0,10,0, 10,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,4,0, 0,1,1));
    tbl.push_back(mk(0,0,1,9,0,0,0,4,0, 4,0,1));
    tbl.push_back(mk(0,0,0,0,1,0,0,4,0, 3,0,1));
    tbl.push_back(mk(0,0,1,9,0,0,0,10,0, 9,0,1));
    tbl.push_back(mk(0,0,0,0,1,0,0,4,0, 4,0,1));
    // clr beats ld; ld beats a step and restarts prescaler
    tbl.push_back(mk(0,1,1,7,0,1,0,10,2, 0,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,10,2, 0,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,10,2, 0,0,0));
    tbl.push_back(mk(0,0,1,7,1,1,0,10,2, 7,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,10,2, 7,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,10,2, 7,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,10,2, 8,0,0));
    // reset mid-operation: count 5, ovf 1, pcnt 1, pre 3
    tbl.push_back(mk(0,0,1,5,0,1,0,5,0, 5,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,5,0, 0,1,1));
    tbl.push_back(mk(0,0,1,5,0,1,0,5,3, 5,0,1));
    tbl.push_back(mk(0,0,0,0,1,1,0,5,3, 5,0,1));
    tbl.push_back(mk(1,0,0,0,1,1,0,5,3, 0,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,5,3, 0,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,5,3, 0,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,5,3, 0,0,0));
    tbl.push_back(mk(0,0,0,0,1,1,0,5,3, 1,0,0));

    foreach (tbl[i]) begin
      drive(tbl[i]);
      cyc($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.tbl_count", i), int'(count), tbl[i].ec);
      chk($sformatf("vec%0d.tbl_tc", i),    int'(tc),    tbl[i].etc);
      chk($sformatf("vec%0d.tbl_ovf", i),   int'(ovf),   tbl[i].eov);
    end

    // limit 0, wrap: every step gives tc and sets ovf
    rst = 0; ld = 0; clr = 1; en = 0;
    cyc("lim0_clr");
    clr = 0; en = 1; limit = 0; pre = 0; sat = 0; up = 1;
    for (int i = 0; i < 3; i++) begin
      cyc("lim0_up");
      chk("lim0_up.tc_hi", int'(tc), 1);
    end
    chk("lim0_up.ovf_hi", int'(ovf), 1);
    up = 0; sat = 1;
    cyc("lim0_dn");
    chk("lim0_dn.count", int'(count), 0);

    // pre lowered below pcnt: pcnt runs to 15, wraps, then matches
    clr = 1; cyc("prew_clr");
    clr = 0; limit = 100; up = 1; sat = 0; pre = 7;
    for (int i = 0; i < 5; i++) cyc("prew_a");
    pre = 2;
    for (int i = 0; i < 13; i++) begin
      cyc("prew_b");
      chk("prew_b.no_step", int'(count), 0);
    end
    cyc("prew_c");
    chk("prew_c.step", int'(count), 1);

    // randomized
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      clr   = ($urandom_range(0, 99) == 0);
      ld    = ($urandom_range(0, 19) == 0);
      data  = 8'($urandom);
      en    = ($urandom_range(0, 9) < 7);
      up    = ($urandom_range(0, 3) != 0) ? up : ~up;
      sat   = ($urandom_range(0, 49) == 0) ? ~sat : sat;
      if ($urandom_range(0, 63) == 0)
        limit = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                            : 8'($urandom_range(0, 6));
      if ($urandom_range(0, 31) == 0)
        pre = 4'($urandom_range(0, 3));
      cyc("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised up/down modulo counter with load, synchronous clear, prescaler, wrap or saturate mode, terminal-count pulse and sticky overflow flag. It generalises the lab's basic increment-on-enable counter into a general-purpose event/timebase counter for later lab blocks such as clock dividers, sequencers and display timers. All state is in a single clock domain.

## Interface

Parameters:
- WIDTH, 8, counter width in bits.
- PRE_W, 4, prescaler width in bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- clr  input  1  synchronous clear of count, prescaler and ovf.
- ld  input  1  load count from data.
- data  input  WIDTH  load value.
- en  input  1  count enable; feeds the prescaler.
- up  input  1  direction: 1 = increment, 0 = decrement.
- sat  input  1  mode: 1 = saturate at bounds, 0 = wrap.
- limit  input  WIDTH  upper bound; count range is 0..limit inclusive.
- pre  input  PRE_W  prescale: one step every pre+1 enabled cycles.
- count  output  WIDTH  registered counter value.
- tc  output  1  registered one-cycle terminal-count pulse.
- ovf  output  1  sticky wrap flag.

## Operation

- Priority at each edge: rst > clr > ld > step > hold.
- rst: count=0, prescaler=0, tc=0, ovf=0.
- clr: count=0, prescaler=0, ovf=0, tc=0.
- ld: count=min(data, limit), prescaler=0, tc=0, ovf unchanged.
- Prescaler: when en=1 and pcnt==pre, a step fires and pcnt is set to 0. When en=1 and pcnt!=pre, pcnt increments. When en=0, pcnt holds. With pre=0, every enabled cycle steps.
- Step, up=1:
  - count<limit: count+1.
  - count>=limit, sat=0: count=0, tc=1, ovf=1.
  - count>=limit, sat=1: count=limit, tc=1, ovf unchanged.
- Step, down (up=0):
  - count>limit: count=limit. No tc. This is the recovery path after limit is lowered.
  - 0<count<=limit: count-1.
  - count==0, sat=0: count=limit, tc=1, ovf=1.
  - count==0, sat=1: count stays 0, tc=1.
- tc is 0 in every cycle not listed above. tc asserts again on every step that hits a bound (held saturation repeats tc each step).
- limit=0: count stays 0. Every step produces tc. In wrap mode, every step also sets ovf.
- Arithmetic is unsigned WIDTH-bit. No intermediate result may exceed WIDTH bits. Bound compares are done before the add/subtract, so there is no reliance on natural overflow.
- limit, sat, up and pre are sampled at every edge and may change at any time. A pre change takes effect at the next compare. If pcnt>pre after a change, pcnt keeps counting up, wraps at 2^PRE_W, then matches.

## Timing

- All outputs are registered. Reset values: count=0, tc=0, ovf=0.
- Latency:
  - Step or ld is visible on count one cycle after the qualifying edge inputs.
  - tc is high in the same cycle as the resulting count value.
- With en held high, steps occur every pre+1 cycles. The first step is pre+1 edges after rst, clr or ld deasserts.
- Simultaneous ld and step: the load wins and the prescaler restarts.
- Simultaneous clr and ld: the clear wins.
- rst mid-count or mid-prescale: everything returns to reset values at the next edge. There is no partial state.
- ovf stays 1 until rst or clr, regardless of later steps or loads.

## Test plan

- Reset and hold:
  - Stimulus: rst for 2 cycles, then en=0 for 5 cycles with ld=0.
  - Response: count=0, tc=0, ovf=0 throughout.
- Wrap up:
  - Stimulus: WIDTH=8, limit=5, pre=0, up=1, sat=0, en=1 for 8 cycles.
  - Response: count sequence 1,2,3,4,5,0,1,2. tc high only with count=0. ovf=1 from that cycle onward.
- Saturate down with prescale:
  - Stimulus: ld data=3, then pre=2, up=0, sat=1, en=1 for 12 cycles.
  - Response: count 3→2→1→0, one step every 3 cycles. count then holds at 0 with tc pulsing every 3rd cycle. ovf stays 0.
- Load clamp and limit lowering:
  - Stimulus 1: limit=10, ld data=200.
  - Response 1: count=10.
  - Stimulus 2: limit=4, one up step.
  - Response 2: count=0, tc=1.
  - Stimulus 3: ld data=9, then one down step.
  - Response 3: count=4, no tc.
- Priority collisions:
  - Stimulus 1: clr=1 with ld=1, data=7.
  - Response 1: count=0, ovf=0.
  - Stimulus 2: ld=1 on a step cycle.
  - Response 2: count=data. The next step comes pre+1 cycles later.
- Reset mid-operation:
  - Stimulus: limit=5, wrap mode, count=5 with ovf=1, pcnt=1 (pre=3), assert rst for one cycle.
  - Response: next cycle count=0, ovf=0, tc=0. The first step follows 4 enabled cycles later.
